// File: rtl/msg_udp_filter.sv
// Buffers the Eth/IPv4/UDP header of each Avalon-ST message, classifies it against a UDP
// destination port and forwards every beat unchanged with a per-message drop flag.
module msg_udp_filter #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned EMPTY_W   = $clog2(DATA_W / 8),
  parameter int unsigned HDR_BEATS = (38 + DATA_W / 8 - 1) / (DATA_W / 8),
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_en,
  input  logic [15:0]        cfg_port,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [EMPTY_W-1:0] in_empty,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sop,
  output logic               out_eop,
  output logic [EMPTY_W-1:0] out_empty,
  output logic               out_drop,
  output logic [CNT_W-1:0]   cnt_pass,
  output logic [CNT_W-1:0]   cnt_filt,
  output logic               err_orphan
);

  localparam int unsigned BPB       = DATA_W / 8;
  localparam int unsigned DEPTH     = HDR_BEATS + 1;
  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned CNT_FW    = $clog2(DEPTH + 1);
  localparam int unsigned BEAT_W    = $clog2(HDR_BEATS + 1);
  localparam int unsigned DEC_BEAT  = 37 / BPB;
  localparam int unsigned EMPTY_MAX = BPB - 1 - (37 % BPB);
  localparam int unsigned NF        = 6;
  // Header byte offsets: ethertype hi/lo, version+IHL, protocol, UDP dst port hi/lo
  localparam int unsigned HDR_IDX [NF] = '{12, 13, 14, 23, 36, 37};

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_FWD, S_DRAIN} state_t;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
  } beat_t;

  state_t             state_q, state_n;
  beat_t              mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_FW-1:0]  count_q, count_n;
  logic [BEAT_W-1:0]  beat_q, cur_beat;
  logic [7:0]         hdr_q [NF];
  logic [7:0]         fld [NF];
  logic               drop_q, drop_n;
  logic               push, pop, orphan, hdr_phase, decide, runt, pass;
  logic               out_valid_n, in_ready_n, out_drop_n;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign out_data  = mem[rd_ptr_q].data;
  assign out_sop   = mem[rd_ptr_q].sop;
  assign out_eop   = mem[rd_ptr_q].eop;
  assign out_empty = mem[rd_ptr_q].empty;

  // Next-state, classification and next values of the registered handshake outputs
  always_comb begin
    state_n   = state_q;
    cur_beat  = (state_q == S_IDLE) ? '0 : beat_q;
    push      = in_valid & in_ready & ((state_q != S_IDLE) | in_sop);
    pop       = out_valid & out_ready;
    orphan    = in_valid & in_ready & (state_q == S_IDLE) & ~in_sop;
    hdr_phase = (state_q == S_IDLE) | (state_q == S_HDR);
    decide    = push & hdr_phase & (in_eop | (cur_beat == BEAT_W'(DEC_BEAT)));

    // Header fields: live lane on the beat that carries them, captured copy otherwise
    for (int i = 0; i < int'(NF); i++) begin
      if (cur_beat == BEAT_W'(HDR_IDX[i] / BPB))
        fld[i] = in_data[DATA_W-1-8*(HDR_IDX[i]%BPB) -: 8];
      else
        fld[i] = hdr_q[i];
    end

    runt = in_eop & ((cur_beat < BEAT_W'(DEC_BEAT)) |
                     ((cur_beat == BEAT_W'(DEC_BEAT)) & (in_empty > EMPTY_W'(EMPTY_MAX))));
    pass = ~cfg_en | (~runt & (fld[0] == 8'h08) & (fld[1] == 8'h00) & (fld[2] == 8'h45) &
                      (fld[3] == 8'h11) & ({fld[4], fld[5]} == cfg_port));

    case (state_q)
      S_IDLE, S_HDR: begin
        if (decide)    state_n = in_eop ? S_DRAIN : S_FWD;
        else if (push) state_n = S_HDR;
      end
      S_FWD:   if (push & in_eop) state_n = S_DRAIN;
      S_DRAIN: if (pop & mem[rd_ptr_q].eop) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    count_n     = count_q + CNT_FW'(push) - CNT_FW'(pop);
    drop_n      = decide ? ~pass : drop_q;
    out_valid_n = ((state_n == S_FWD) | (state_n == S_DRAIN)) & (count_n != '0);
    in_ready_n  = (state_n == S_IDLE) |
                  (((state_n == S_HDR) | (state_n == S_FWD)) & (count_n < CNT_FW'(DEPTH)));
    out_drop_n  = drop_n & out_valid_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beat_q     <= '0;
      drop_q     <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_drop   <= 1'b0;
      err_orphan <= 1'b0;
      cnt_pass   <= '0;
      cnt_filt   <= '0;
      for (int i = 0; i < int'(NF); i++) hdr_q[i] <= '0;
    end else begin
      state_q    <= state_n;
      count_q    <= count_n;
      drop_q     <= drop_n;
      in_ready   <= in_ready_n;
      out_valid  <= out_valid_n;
      out_drop   <= out_drop_n;
      err_orphan <= orphan;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (state_n == S_IDLE)
        beat_q <= '0;
      else if (push & hdr_phase & ~decide)
        beat_q <= cur_beat + BEAT_W'(1);
      if (push & hdr_phase)
        for (int i = 0; i < int'(NF); i++) hdr_q[i] <= fld[i];
      if (decide) begin
        if (pass) cnt_pass <= cnt_pass + CNT_W'(1);
        else      cnt_filt <= cnt_filt + CNT_W'(1);
      end
    end
  end

  // Beat storage; contents are only meaningful where count_q says so
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {in_data, in_sop, in_eop, in_empty};
  end

endmodule

// File: tb/tb_msg_udp_filter.sv
// Directed bench for msg_udp_filter (DATA_W=64): vector table of frames plus
// hand-written flow-control, back-to-back, orphan and reset sequences.
module tb_msg_udp_filter;

  logic        clk, rst_n, cfg_en;
  logic [15:0] cfg_port;
  logic [63:0] in_data, out_data;
  logic        in_valid, in_ready, in_sop, in_eop;
  logic [2:0]  in_empty, out_empty;
  logic        out_valid, out_ready, out_sop, out_eop, out_drop, err_orphan;
  logic [15:0] cnt_pass, cnt_filt;

  msg_udp_filter #(.DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_port(cfg_port),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop),
    .in_eop(in_eop), .in_empty(in_empty), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
    .out_drop(out_drop), .cnt_pass(cnt_pass), .cnt_filt(cnt_filt), .err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
    logic        drop;
    int          cyc;
  } obeat_t;

  typedef struct {
    logic        en;
    logic [15:0] port;
    logic [15:0] eth;
    logic [7:0]  vh;
    logic [7:0]  proto;
    logic [15:0] dport;
    int          len;
    logic        drop;
    int          lat_ref;  // 0 none, 1 from input SOP, 2 from input EOP
    int          lat;
  } vec_t;

  obeat_t oq[$], eq[$];
  int     in_sop_q[$], in_eop_q[$], out_eop_q[$];
  int     in_acc_cnt = 0, stall_viol = 0, drop_viol = 0;
  int     checks = 0, errors = 0, exp_pass = 0, exp_filt = 0;
  logic   prev_stall = 1'b0;
  logic [63:0] p_data;
  logic [5:0]  p_ctl;
  logic [7:0]  fb [128];
  vec_t        vt [12];

  // Output/input monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!out_valid || out_data !== p_data ||
          {out_sop, out_eop, out_empty, out_drop} !== p_ctl)) stall_viol++;
      if (!out_valid && out_drop) drop_viol++;
      if (out_valid && out_ready) begin
        oq.push_back('{out_data, out_sop, out_eop, out_empty, out_drop, cyc});
        if (out_eop) out_eop_q.push_back(cyc);
      end
      if (in_valid && in_ready) begin
        in_acc_cnt++;
        if (in_sop) in_sop_q.push_back(cyc);
        if (in_eop) in_eop_q.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      p_data     = out_data;
      p_ctl      = {out_sop, out_eop, out_empty, out_drop};
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic build_frame(input logic [15:0] eth, input logic [7:0] vh,
                             input logic [7:0] proto, input logic [15:0] dport,
                             input logic [7:0] seed);
    for (int i = 0; i < 128; i++) fb[i] = 8'(i * 13) + seed;
    fb[12] = eth[15:8];
    fb[13] = eth[7:0];
    fb[14] = vh;
    fb[23] = proto;
    fb[36] = dport[15:8];
    fb[37] = dport[7:0];
  endtask

  function automatic logic [63:0] beat_data(input int b);
    logic [63:0] d = '0;
    for (int k = 0; k < 8; k++) d = {d[55:0], fb[8*b+k]};
    return d;
  endfunction

  task automatic drive_beat(input logic [63:0] d, input logic s, input logic e,
                            input logic [2:0] em);
    int   n = 0;
    logic acc = 1'b0;
    in_data = d; in_sop = s; in_eop = e; in_empty = em; in_valid = 1'b1;
    while (!acc && n < 500) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL drive_timeout: got in_ready 0 expected 1 within 500 cycles");
    end
  endtask

  task automatic send_frame(input int len, input logic drop);
    int nb = (len + 7) / 8;
    obeat_t e;
    for (int b = 0; b < nb; b++) begin
      e.data  = beat_data(b);
      e.sop   = (b == 0);
      e.eop   = (b == nb - 1);
      e.empty = (b == nb - 1) ? 3'(nb * 8 - len) : 3'd0;
      e.drop  = drop;
      e.cyc   = 0;
      eq.push_back(e);
      drive_beat(e.data, e.sop, e.eop, e.empty);
    end
  endtask

  task automatic wait_eops(input int n);
    int k = 0;
    while (out_eop_q.size() < n && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    if (out_eop_q.size() < n) begin
      checks++; errors++;
      $display("FAIL eop_timeout: got %0d eop beats expected %0d", out_eop_q.size(), n);
    end
  endtask

  task automatic compare_out(input string tag);
    check({tag, "_nbeats"}, 64'(oq.size()), 64'(eq.size()));
    for (int i = 0; i < eq.size() && i < oq.size(); i++) begin
      check($sformatf("%s_b%0d_data", tag, i), oq[i].data, eq[i].data);
      check($sformatf("%s_b%0d_sop_eop_empty_drop", tag, i),
            64'({oq[i].sop, oq[i].eop, oq[i].empty, oq[i].drop}),
            64'({eq[i].sop, eq[i].eop, eq[i].empty, eq[i].drop}));
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_cnt_pass"}, 64'(cnt_pass), 64'(exp_pass));
    check({tag, "_cnt_filt"}, 64'(cnt_filt), 64'(exp_filt));
  endtask

  task automatic clear_queues();
    oq.delete(); eq.delete();
    in_sop_q.delete(); in_eop_q.delete(); out_eop_q.delete();
  endtask

  initial begin
    //         en    port      eth       vh     proto  dport     len drop ref lat
    vt[0]  = '{1'b1, 16'h07D0, 16'h0800, 8'h45, 8'h11, 16'h07D0, 42, 1'b0, 1, 5};
    vt[1]  = '{1'b1, 16'h1234, 16'h0800, 8'h45, 8'h11, 16'h07D0, 42, 1'b1, 1, 5};
    vt[2]  = '{1'b0, 16'h07D0, 16'h86DD, 8'h45, 8'h11, 16'h07D0, 42, 1'b0, 0, 0};
    vt[3]  = '{1'b1, 16'h07D0, 16'h86DD, 8'h45, 8'h11, 16'h07D0, 42, 1'b1, 0, 0};
    vt[4]  = '{1'b1, 16'h07D0, 16'h0800, 8'h45, 8'h11, 16'h07D0, 16, 1'b1, 2, 1};
    vt[5]  = '{1'b0, 16'h07D0, 16'h0800, 8'h45, 8'h11, 16'h07D0, 16, 1'b0, 0, 0};
    vt[6]  = '{1'b1, 16'h07D0, 16'h0800, 8'h45, 8'h11, 16'h07D0, 37, 1'b1, 0, 0};
    vt[7]  = '{1'b1, 16'h07D0, 16'h0800, 8'h45, 8'h11, 16'h07D0, 38, 1'b0, 0, 0};
    vt[8]  = '{1'b1, 16'h07D0, 16'h0800, 8'h45, 8'h06, 16'h07D0, 42, 1'b1, 0, 0};
    vt[9]  = '{1'b1, 16'h07D0, 16'h0800, 8'h46, 8'h11, 16'h07D0, 42, 1'b1, 0, 0};
    vt[10] = '{1'b1, 16'h07D0, 16'h0800, 8'h45, 8'h11, 16'h07D0,  8, 1'b1, 2, 1};
    vt[11] = '{1'b1, 16'h07D0, 16'h0800, 8'h45, 8'h11, 16'hD007, 42, 1'b1, 0, 0};

    rst_n = 1'b0; cfg_en = 1'b1; cfg_port = 16'h07D0; out_ready = 1'b1;
    in_data = '0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_empty = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_drop", 64'(out_drop), 64'd0);
    check("rst_cnt_pass", 64'(cnt_pass), 64'd0);
    check("rst_cnt_filt", 64'(cnt_filt), 64'd0);
    check("rst_err_orphan", 64'(err_orphan), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // Table-driven classification vectors
    for (int v = 0; v < 12; v++) begin
      clear_queues();
      cfg_en = vt[v].en; cfg_port = vt[v].port; out_ready = 1'b1;
      build_frame(vt[v].eth, vt[v].vh, vt[v].proto, vt[v].dport, 8'(v * 17));
      send_frame(vt[v].len, vt[v].drop);
      wait_eops(1);
      if (vt[v].drop) exp_filt++; else exp_pass++;
      compare_out($sformatf("v%0d", v));
      check_counters($sformatf("v%0d", v));
      if (vt[v].lat_ref == 1 && oq.size() > 0 && in_sop_q.size() > 0)
        check($sformatf("v%0d_lat_from_sop", v), 64'(oq[0].cyc - in_sop_q[0]), 64'(vt[v].lat));
      else if (vt[v].lat_ref == 2 && oq.size() > 0 && in_eop_q.size() > 0)
        check($sformatf("v%0d_lat_from_eop", v), 64'(oq[0].cyc - in_eop_q[0]), 64'(vt[v].lat));
    end

    // Backpressure: FIFO fills to 6 entries, then out_ready toggles 1-0-1-0
    begin
      int base;
      clear_queues();
      cfg_en = 1'b1; cfg_port = 16'h07D0; out_ready = 1'b0;
      build_frame(16'h0800, 8'h45, 8'h11, 16'h07D0, 8'h5A);
      base = in_acc_cnt;
      fork
        send_frame(80, 1'b0);
        begin
          int n = 0;
          while (in_acc_cnt - base < 6 && n < 200) begin
            @(posedge clk); #1;
            n++;
          end
          @(negedge clk);
          check("full_in_ready", 64'(in_ready), 64'd0);
          check("full_out_valid", 64'(out_valid), 64'd1);
          check("full_no_pop", 64'(oq.size()), 64'd0);
          repeat (3) @(negedge clk);
          check("full_hold_in_ready", 64'(in_ready), 64'd0);
          check("full_hold_accepted", 64'(in_acc_cnt - base), 64'd6);
          @(posedge clk); #1;
          n = 0;
          out_ready = 1'b1;
          while (out_eop_q.size() < 1 && n < 400) begin
            @(posedge clk); #1;
            out_ready = ~out_ready;
            n++;
          end
          out_ready = 1'b1;
        end
      join
      wait_eops(1);
      exp_pass++;
      compare_out("bp");
      check_counters("bp");
    end

    // Three back-to-back frames: next SOP accepted the cycle after the previous EOP pops
    clear_queues();
    out_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      build_frame(16'h0800, 8'h45, 8'h11, (f == 1) ? 16'h0050 : 16'h07D0, 8'(f * 29 + 3));
      send_frame(42, f == 1);
    end
    wait_eops(3);
    exp_pass += 2;
    exp_filt += 1;
    compare_out("b2b");
    check_counters("b2b");
    for (int f = 1; f < 3; f++) begin
      if (in_sop_q.size() > f && out_eop_q.size() >= f)
        check($sformatf("b2b_sop%0d_after_eop", f), 64'(in_sop_q[f]), 64'(out_eop_q[f-1] + 1));
    end

    // Orphan beat in IDLE
    clear_queues();
    repeat (2) @(posedge clk);
    #1;
    check("orphan_before", 64'(err_orphan), 64'd0);
    drive_beat(64'hDEAD_BEEF_0123_4567, 1'b0, 1'b1, 3'd0);
    check("orphan_pulse", 64'(err_orphan), 64'd1);
    @(posedge clk); #1;
    check("orphan_clear", 64'(err_orphan), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check("orphan_no_output", 64'(oq.size()), 64'd0);
    check("orphan_out_valid", 64'(out_valid), 64'd0);
    check_counters("orphan");

    // Reset while in HDR, then a clean frame
    clear_queues();
    build_frame(16'h0800, 8'h45, 8'h11, 16'h07D0, 8'h77);
    for (int b = 0; b < 3; b++) drive_beat(beat_data(b), b == 0, 1'b0, 3'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_cnt_pass", 64'(cnt_pass), 64'd0);
    check("midrst_cnt_filt", 64'(cnt_filt), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_pass = 0;
    exp_filt = 0;
    @(posedge clk); #1;
    clear_queues();
    send_frame(42, 1'b0);
    wait_eops(1);
    exp_pass++;
    compare_out("postrst");
    check_counters("postrst");
    if (oq.size() > 0 && in_sop_q.size() > 0)
      check("postrst_lat_from_sop", 64'(oq[0].cyc - in_sop_q[0]), 64'd5);

    check("stall_stability_violations", 64'(stall_viol), 64'd0);
    check("drop_without_valid", 64'(drop_viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
